crp16_alu_issue: RTL and testbench

CRP16_ALU_ISSUE -- requirements
Module: crp16_alu_issue

---
 rtl/crp16_alu_issue.sv | 267 ++++++++++++++++++++++++++
 tb/tb_crp16_alu_issue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/crp16_alu_issue.sv
// crp16_alu_issue: two-stage issue wrapper around the crp16 ALU.
//   S1 holds the accepted request (op, operands, ALU select, setf).
//   S2 holds the ALU result, its flags, write-back and illegal markers.
//   A {v,c,n,z} flag register is loaded when a setf op retires, and
//   cond_true evaluates a 16-way branch condition from it.
// Optional feature macro: CRP16_ALU_ISSUE_FLAG_FWD_EN
//   Defined   : cond_true sees the retiring S2 flags in the cycle they load.
//   Undefined : cond_true sees only the registered flags (one cycle later).

// Combinational 16-bit ALU. Shift amount is b[3:0]; for shifts, c is the
// last bit shifted out (0 for a zero shift) and v is 0. Logic ops clear c, v.
// SUB carry is "no borrow" (a + ~b + 1 carry-out).
module crp16_alu (
  input  logic [3:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        v,
  output logic        c,
  output logic        n,
  output logic        z
);

  // Result and flag generation for the selected operation.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (sel)
      4'b0000: begin
        {c, result} = {1'b0, a} + {1'b0, b};
        v = (a[15] == b[15]) && (result[15] != a[15]);
      end
      4'b0001: begin
        {c, result} = {1'b0, a} + {1'b0, ~b} + 17'd1;
        v = (a[15] != b[15]) && (result[15] != a[15]);
      end
      4'b1000: {c, result} = {1'b0, a} << b[3:0];
      4'b1010: {result, c} = {a, 1'b0} >> b[3:0];
      4'b1011: {result, c} = $signed({a, 1'b0}) >>> b[3:0];
      4'b1100: result = a & b;
      4'b1101: result = a | b;
      4'b1110: result = ~a;
      4'b1111: result = a ^ b;
      default: result = '0;
    endcase
    n = result[15];
    z = (result == 16'h0000);
  end

endmodule

module crp16_alu_issue (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic        in_setf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_wb,
  output logic        out_illegal,
  input  logic [3:0]  cond,
  output logic        cond_true,
  output logic [3:0]  flags
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_CMP = 4'd2, OP_SHL = 4'd3,
    OP_SHR = 4'd4, OP_SAR = 4'd5, OP_AND = 4'd6, OP_OR  = 4'd7,
    OP_NOT = 4'd8, OP_XOR = 4'd9
  } op_e;

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [3:0]  s1_op_q,    s1_op_d;
  logic [15:0] s1_x_q,     s1_x_d;
  logic [15:0] s1_y_q,     s1_y_d;
  logic [3:0]  s1_sel_q,   s1_sel_d;
  logic        s1_setf_q,  s1_setf_d;

  // Stage 2 state
  logic        s2_valid_q,   s2_valid_d;
  logic [15:0] s2_data_q,    s2_data_d;
  logic [3:0]  s2_flags_q,   s2_flags_d;
  logic        s2_wb_q,      s2_wb_d;
  logic        s2_illegal_q, s2_illegal_d;
  logic        s2_setf_q,    s2_setf_d;

  // Architectural flag register {v,c,n,z}
  logic [3:0]  flags_q, flags_d;

  logic        s2_advance;
  logic        s1_advance;
  logic        accept;
  logic        flag_load;
  logic        s1_illegal;
  logic [3:0]  in_sel;
  logic [15:0] alu_result;
  logic        alu_v, alu_c, alu_n, alu_z;
  logic [3:0]  cond_flags;

  crp16_alu u_alu (
    .sel    (s1_sel_q),
    .a      (s1_x_q),
    .b      (s1_y_q),
    .result (alu_result),
    .v      (alu_v),
    .c      (alu_c),
    .n      (alu_n),
    .z      (alu_z)
  );

  // Handshake: a stage moves whenever the stage ahead of it can move.
  always_comb begin
    s2_advance = !s2_valid_q || out_ready;
    s1_advance = s2_advance;
    in_ready   = !s1_valid_q || s1_advance;
    accept     = in_valid && in_ready;
    flag_load  = s2_valid_q && out_ready && s2_setf_q && !s2_illegal_q;
    s1_illegal = (s1_op_q > OP_XOR);
  end

  // Opcode to ALU select; illegal ops run an ADD whose result is discarded.
  always_comb begin
    in_sel = 4'b0000;
    case (in_op)
      OP_ADD:         in_sel = 4'b0000;
      OP_SUB, OP_CMP: in_sel = 4'b0001;
      OP_SHL:         in_sel = 4'b1000;
      OP_SHR:         in_sel = 4'b1010;
      OP_SAR:         in_sel = 4'b1011;
      OP_AND:         in_sel = 4'b1100;
      OP_OR:          in_sel = 4'b1101;
      OP_NOT:         in_sel = 4'b1110;
      OP_XOR:         in_sel = 4'b1111;
      default:        in_sel = 4'b0000;
    endcase
  end

  // Stage 1 next state: empties or refills whenever in_ready is high.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_sel_d   = s1_sel_q;
    s1_setf_d  = s1_setf_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_op_d   = in_op;
      s1_x_d    = in_x;
      s1_y_d    = in_y;
      s1_sel_d  = in_sel;
      s1_setf_d = in_setf;
    end
  end

  // Stage 2 next state: captures the ALU output when S1 moves forward.
  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_flags_d   = s2_flags_q;
    s2_wb_d      = s2_wb_q;
    s2_illegal_d = s2_illegal_q;
    s2_setf_d    = s2_setf_q;
    if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d    = s1_illegal ? 16'h0000 : alu_result;
        s2_flags_d   = {alu_v, alu_c, alu_n, alu_z};
        s2_wb_d      = !s1_illegal && (s1_op_q != OP_CMP);
        s2_illegal_d = s1_illegal;
        s2_setf_d    = s1_setf_q;
      end
    end
  end

  // Flag register loads only when a legal setf op actually retires.
  always_comb begin
    flags_d = flag_load ? s2_flags_q : flags_q;
  end

  // All pipeline and flag state; async reset discards in-flight requests.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: payload registers are reset too, so out_data/out_wb/out_illegal read 0 during reset.
    if (!resetn) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_sel_q     <= '0;
      s1_setf_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_flags_q   <= '0;
      s2_wb_q      <= 1'b0;
      s2_illegal_q <= 1'b0;
      s2_setf_q    <= 1'b0;
      flags_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_sel_q     <= s1_sel_d;
      s1_setf_q    <= s1_setf_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_flags_q   <= s2_flags_d;
      s2_wb_q      <= s2_wb_d;
      s2_illegal_q <= s2_illegal_d;
      s2_setf_q    <= s2_setf_d;
      flags_q      <= flags_d;
    end
  end

  // Flags seen by the condition evaluator.
  always_comb begin
`ifdef CRP16_ALU_ISSUE_FLAG_FWD_EN
    cond_flags = flag_load ? s2_flags_q : flags_q;
`else
    cond_flags = flags_q;
`endif
  end

  // Branch condition evaluation over {v,c,n,z}.
  always_comb begin
    logic fv, fc, fn, fz;
    {fv, fc, fn, fz} = cond_flags;
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = fz;
      4'd1:  cond_true = !fz;
      4'd2:  cond_true = fc;
      4'd3:  cond_true = !fc;
      4'd4:  cond_true = fn;
      4'd5:  cond_true = !fn;
      4'd6:  cond_true = fv;
      4'd7:  cond_true = !fv;
      4'd8:  cond_true = fc && !fz;
      4'd9:  cond_true = !fc || fz;
      4'd10: cond_true = (fn == fv);
      4'd11: cond_true = (fn != fv);
      4'd12: cond_true = !fz && (fn == fv);
      4'd13: cond_true = fz || (fn != fv);
      4'd14: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Output mapping.
  always_comb begin
    out_valid   = s2_valid_q;
    out_data    = s2_data_q;
    out_wb      = s2_wb_q;
    out_illegal = s2_illegal_q;
    flags       = flags_q;
  end

endmodule

// File: tb/tb_crp16_alu_issue.sv
// Directed testbench for crp16_alu_issue. Inputs change 1ns after each
// rising edge; outputs are checked at that point, well away from the edge.
module tb_crp16_alu_issue;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_setf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_wb;
  logic        out_illegal;
  logic [3:0]  cond;
  logic        cond_true;
  logic [3:0]  flags;

  int errors = 0;
  int checks = 0;

  crp16_alu_issue dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_setf     (in_setf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_wb      (out_wb),
    .out_illegal (out_illegal),
    .cond        (cond),
    .cond_true   (cond_true),
    .flags       (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [15:0] x,
                     input logic [15:0] y, input logic setf);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = x;
    in_y     = y;
    in_setf  = setf;
  endtask

  logic [15:0] cond_tbl;
  logic        fwd_exp;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_x      = 16'h0;
    in_y      = 16'h0;
    in_setf   = 1'b0;
    out_ready = 1'b1;
    cond      = 4'd0;

    // Reset state
    #12;
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_out_data", out_data, 16'h0000);
    chk_b("rst_out_wb", out_wb, 1'b0);
    chk_b("rst_out_illegal", out_illegal, 1'b0);
    chk_w("rst_flags", {12'h0, flags}, 16'h0000);
    tick();
    resetn = 1'b1;
    tick();

    // ADD 0x7FFF + 0x0001 with setf: overflow into sign bit
    req(4'd0, 16'h7FFF, 16'h0001, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_b("add_not_yet_valid", out_valid, 1'b0);
    tick();
    chk_b("add_out_valid", out_valid, 1'b1);
    chk_w("add_out_data", out_data, 16'h8000);
    chk_b("add_out_wb", out_wb, 1'b1);
    chk_b("add_out_illegal", out_illegal, 1'b0);
    tick();
    chk_b("add_retired", out_valid, 1'b0);
    chk_w("add_flags", {12'h0, flags}, 16'h000A);
    cond = 4'd10;
    #1 chk_b("add_cond_ge", cond_true, 1'b1);
    cond = 4'd11;
    #1 chk_b("add_cond_lt", cond_true, 1'b0);

    // CMP 5,5: no write-back, z=1 c=1; EQ visibility depends on forwarding
    req(4'd2, 16'h0005, 16'h0005, 1'b1);
    cond = 4'd0;
    tick();
    in_valid = 1'b0;
    tick();
    chk_b("cmp_out_valid", out_valid, 1'b1);
    chk_b("cmp_out_wb", out_wb, 1'b0);
    chk_w("cmp_out_data", out_data, 16'h0000);
`ifdef CRP16_ALU_ISSUE_FLAG_FWD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif
    chk_b("cmp_eq_retire_cycle", cond_true, fwd_exp);
    tick();
    chk_w("cmp_flags", {12'h0, flags}, 16'h0005);
    chk_b("cmp_eq_after", cond_true, 1'b1);

    // All 16 conditions with flags {v,c,n,z}=0101
    cond_tbl = 16'h66A5;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      #1 chk_b($sformatf("cond_%0d", i), cond_true, cond_tbl[i]);
    end

    // SAR then SHR back-to-back
    tick();
    req(4'd5, 16'h8000, 16'h0004, 1'b0);
    tick();
    req(4'd4, 16'h8000, 16'h0004, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_b("sar_out_valid", out_valid, 1'b1);
    chk_w("sar_out_data", out_data, 16'hF800);
    tick();
    chk_b("shr_out_valid", out_valid, 1'b1);
    chk_w("shr_out_data", out_data, 16'h0800);
    tick();
    chk_b("shift_drained", out_valid, 1'b0);
    chk_w("shift_flags_kept", {12'h0, flags}, 16'h0005);

    // Four requests against a 5-cycle out_ready stall
    out_ready = 1'b0;
    req(4'd0, 16'h0001, 16'h0002, 1'b0);
    chk_b("stall_rdy_a", in_ready, 1'b1);
    tick();
    req(4'd1, 16'h000A, 16'h0003, 1'b0);
    chk_b("stall_rdy_b", in_ready, 1'b1);
    tick();
    req(4'd9, 16'hF0F0, 16'hFFFF, 1'b0);
    chk_b("stall_rdy_c_blocked", in_ready, 1'b0);
    chk_b("stall_out_valid", out_valid, 1'b1);
    chk_w("stall_out_a", out_data, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b($sformatf("stall_hold_rdy_%0d", i), in_ready, 1'b0);
      chk_w($sformatf("stall_hold_data_%0d", i), out_data, 16'h0003);
    end
    out_ready = 1'b1;
    #1 chk_b("stall_release_rdy", in_ready, 1'b1);
    tick();
    req(4'd6, 16'h1234, 16'h00FF, 1'b0);
    chk_w("stall_out_b", out_data, 16'h0007);
    tick();
    in_valid = 1'b0;
    chk_w("stall_out_c", out_data, 16'h0F0F);
    tick();
    chk_b("stall_d_valid", out_valid, 1'b1);
    chk_w("stall_out_d", out_data, 16'h0034);
    tick();
    chk_b("stall_drained", out_valid, 1'b0);

    // Illegal op with setf: completes, no flag update
    req(4'd12, 16'h0001, 16'h0001, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_b("ill_out_valid", out_valid, 1'b1);
    chk_b("ill_out_illegal", out_illegal, 1'b1);
    chk_w("ill_out_data", out_data, 16'h0000);
    chk_b("ill_out_wb", out_wb, 1'b0);
    tick();
    chk_w("ill_flags_kept", {12'h0, flags}, 16'h0005);

    // Reset while both stages hold requests
    out_ready = 1'b0;
    req(4'd0, 16'h0001, 16'h0001, 1'b1);
    tick();
    req(4'd0, 16'h0002, 16'h0002, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_b("mid_full_valid", out_valid, 1'b1);
    chk_b("mid_full_blocked", in_ready, 1'b0);
    resetn = 1'b0;
    #1;
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_w("mid_rst_flags", {12'h0, flags}, 16'h0000);
    chk_b("mid_rst_in_ready", in_ready, 1'b1);
    chk_w("mid_rst_out_data", out_data, 16'h0000);
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    tick();
    req(4'd1, 16'h0003, 16'h0004, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk_b("post_rst_valid", out_valid, 1'b1);
    chk_w("post_rst_data", out_data, 16'hFFFF);
    tick();
    chk_w("post_rst_flags", {12'h0, flags}, 16'h0002);
    chk_b("post_rst_drained", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
